// File: rtl/spi_pwm_host.sv
// Host-side SPI mode-0 master for the PWM expander: one register request becomes one
// 16-bit frame {RW, 5'b0, Channel, Duty|0x00}; the low reply byte is kept on reads.
module spi_pwm_host #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic       CLK,
    input  logic       _RST,
    input  logic       Start,
    input  logic       RW,
    input  logic [1:0] Channel,
    input  logic [7:0] Duty,
    output logic       Busy,
    output logic       Done,
    output logic [7:0] RdData,
    output logic       _CS,
    output logic       SCLK,
    output logic       MOSI,
    input  logic       MISO
);

    localparam int MAXC = (CLK_DIV > CS_SETUP) ? ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD)
                                               : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
    localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] DIV_END   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_END = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_END  = CW'(CS_HOLD - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [4:0]    bit_cnt;
    logic [14:0]   tx;      // frame bits 14:0; bit 15 goes straight to MOSI at accept
    logic [7:0]    rx;      // only the last eight sampled bits are ever observable
    logic          rw_q;

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            tx      <= '0;
            rx      <= '0;
            rw_q    <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            RdData  <= 8'h00;
            _CS     <= 1'b1;
            SCLK    <= 1'b0;
            MOSI    <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        state   <= SETUP;
                        cnt     <= '0;
                        bit_cnt <= '0;
                        rw_q    <= RW;
                        tx      <= {5'b0, Channel, (RW ? 8'h00 : Duty)};
                        MOSI    <= RW;
                        _CS     <= 1'b0;
                        Busy    <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_END) begin
                        state <= SHIFT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt == DIV_END) begin
                        cnt <= '0;
                        if (!SCLK) begin
                            SCLK    <= 1'b1;
                            rx      <= {rx[6:0], MISO};
                            bit_cnt <= bit_cnt + 5'd1;
                        end else begin
                            SCLK <= 1'b0;
                            // the fall after the 16th rise ends the frame instead of advancing MOSI
                            if (bit_cnt == 5'd16) begin
                                state <= HOLD;
                                MOSI  <= 1'b0;
                                if (rw_q)
                                    RdData <= rx;
                            end else begin
                                MOSI <= tx[14];
                                tx   <= {tx[13:0], 1'b0};
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_END) begin
                        state <= GAP;
                        cnt   <= '0;
                        _CS   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == DIV_END) begin
                        state <= IDLE;
                        cnt   <= '0;
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_pwm_host.sv
// Bench for spi_pwm_host: a default-parameter instance and a fastest-timing instance,
// with a frame monitor that scores each Done against queued expectations.
module tb_spi_pwm_host;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       rst_n;
    logic [1:0] start, rw;
    logic [1:0] ch [2];
    logic [7:0] duty [2];
    logic [1:0] busy, done, cs_n, sclk, mosi;
    logic [7:0] rd [2];
    logic       miso0;

    spi_pwm_host u0 (
        .CLK(CLK), ._RST(rst_n), .Start(start[0]), .RW(rw[0]), .Channel(ch[0]), .Duty(duty[0]),
        .Busy(busy[0]), .Done(done[0]), .RdData(rd[0]), ._CS(cs_n[0]), .SCLK(sclk[0]),
        .MOSI(mosi[0]), .MISO(miso0)
    );

    spi_pwm_host #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) u1 (
        .CLK(CLK), ._RST(rst_n), .Start(start[1]), .RW(rw[1]), .Channel(ch[1]), .Duty(duty[1]),
        .Busy(busy[1]), .Done(done[1]), .RdData(rd[1]), ._CS(cs_n[1]), .SCLK(sclk[1]),
        .MOSI(mosi[1]), .MISO(1'b1)
    );

    // Mode-0 responder for u0: presents reply bit (15 - rises seen) before each rise.
    logic [15:0] resp = 16'hC33C;
    logic [4:0]  rc;
    logic        sclk_q;
    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rc     <= '0;
            sclk_q <= 1'b0;
        end else begin
            sclk_q <= sclk[0];
            if (cs_n[0])
                rc <= '0;
            else if (sclk[0] && !sclk_q)
                rc <= rc + 5'd1;
        end
    end
    always_comb miso0 = (rc < 5'd16) ? resp[15 - int'(rc)] : 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    typedef struct {
        int          d;
        logic [15:0] word;
        logic [7:0]  rd;
        int          first;
        int          csh;
        int          dn;
        int          pre;
    } exp_t;
    exp_t sb[$];

    // Offsets are relative to the _CS fall cycle (accept edge + 1).
    task automatic expect_frame(input int d, input logic [15:0] w, input logic [7:0] r, input int pre);
        exp_t e;
        e.d = d; e.word = w; e.rd = r; e.pre = pre;
        if (d == 0) begin e.first = 6; e.csh = 132; e.dn = 136; end
        else        begin e.first = 2; e.csh = 34;  e.dn = 35;  end
        sb.push_back(e);
    endtask

    int          cyc = 0;
    int          fall_c [2], first_c [2], csh_c [2], rises [2], last_csr [2], pre_c [2];
    logic [15:0] word [2];
    logic        prev_cs [2], prev_sclk [2];

    always @(negedge CLK) begin
        exp_t e;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                check($sformatf("rst_cs%0d", d), cs_n[d], 1);
                check($sformatf("rst_sclk%0d", d), sclk[d], 0);
                check($sformatf("rst_mosi%0d", d), mosi[d], 0);
                check($sformatf("rst_busy%0d", d), busy[d], 0);
                check($sformatf("rst_done%0d", d), done[d], 0);
                check($sformatf("rst_rd%0d", d), rd[d], 0);
                prev_cs[d] = 1'b1; prev_sclk[d] = 1'b0; last_csr[d] = -1; rises[d] = 0;
            end else begin
                if (prev_cs[d] && !cs_n[d]) begin
                    fall_c[d] = cyc; rises[d] = 0; word[d] = '0;
                    pre_c[d] = (last_csr[d] >= 0) ? cyc - last_csr[d] : -1;
                end
                if (!prev_sclk[d] && sclk[d]) begin
                    rises[d]++;
                    word[d] = {word[d][14:0], mosi[d]};
                    if (rises[d] == 1) begin
                        first_c[d] = cyc - fall_c[d];
                        check($sformatf("busy_in_frame%0d", d), busy[d], 1);
                    end
                end
                if (!prev_cs[d] && cs_n[d]) begin
                    csh_c[d] = cyc - fall_c[d];
                    last_csr[d] = cyc;
                end
                if (done[d]) begin
                    if (sb.size() == 0 || sb[0].d != d) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done%0d actual=1 required=0", d);
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("mosi_word%0d", d), word[d], e.word);
                        check($sformatf("rises%0d", d), rises[d], 16);
                        check($sformatf("rddata%0d", d), rd[d], e.rd);
                        check($sformatf("first_rise%0d", d), first_c[d], e.first);
                        check($sformatf("cs_high_at%0d", d), csh_c[d], e.csh);
                        check($sformatf("done_at%0d", d), cyc - fall_c[d], e.dn);
                        check($sformatf("busy_at_done%0d", d), busy[d], 0);
                        if (e.pre >= 0)
                            check($sformatf("gap_cycles%0d", d), pre_c[d], e.pre);
                    end
                end
                prev_cs[d] = cs_n[d];
                prev_sclk[d] = sclk[d];
            end
        end
    end

    task automatic issue(input int d, input logic r, input logic [1:0] c, input logic [7:0] du);
        @(posedge CLK); #1;
        rw[d] = r; ch[d] = c; duty[d] = du; start[d] = 1'b1;
        @(posedge CLK); #1;
        start[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int budget);
        int got = 0;
        for (int i = 0; i < budget && got == 0; i++) begin
            @(negedge CLK);
            if (done[d]) got = 1;
        end
        check($sformatf("done_seen%0d", d), got, 1);
    endtask

    task automatic wait_cs_low(input int d, input int budget);
        int got = 0;
        for (int i = 0; i < budget && got == 0; i++) begin
            @(negedge CLK);
            if (!cs_n[d]) got = 1;
        end
        check($sformatf("cs_fall_seen%0d", d), got, 1);
    endtask

    initial begin
        int r;
        logic ps;
        rst_n = 1'b0; start = '0; rw = '0;
        ch[0] = '0; ch[1] = '0; duty[0] = '0; duty[1] = '0;
        repeat (6) begin
            @(posedge CLK); #1;
            start = ~start;
        end
        start = '0;
        @(negedge CLK); rst_n = 1'b1;
        repeat (3) @(posedge CLK);

        expect_frame(0, 16'h02A5, 8'h00, -1);
        issue(0, 1'b0, 2'd2, 8'hA5);
        wait_done(0, 300);

        expect_frame(0, 16'h8100, 8'h3C, -1);
        issue(0, 1'b1, 2'd1, 8'h77);
        wait_done(0, 300);

        // Start pulsed mid-frame with different content must be dropped.
        expect_frame(0, 16'h0012, 8'h3C, -1);
        issue(0, 1'b0, 2'd0, 8'h12);
        repeat (48) @(posedge CLK);
        #1; ch[0] = 2'd3; duty[0] = 8'hEE; start[0] = 1'b1;
        @(posedge CLK); #1; start[0] = 1'b0;
        wait_done(0, 300);
        repeat (200) @(posedge CLK);

        // Abort on reset just after rise 8.
        issue(0, 1'b0, 2'd1, 8'h55);
        r = 0; ps = 1'b0;
        for (int i = 0; i < 300 && r < 8; i++) begin
            @(negedge CLK);
            if (sclk[0] && !ps) r++;
            ps = sclk[0];
        end
        check("rise8_seen", r, 8);
        #2 rst_n = 1'b0;
        #1;
        check("async_cs", cs_n[0], 1);
        check("async_sclk", sclk[0], 0);
        repeat (3) @(posedge CLK);
        @(negedge CLK); rst_n = 1'b1;
        repeat (2) @(posedge CLK);
        expect_frame(0, 16'h00FF, 8'h00, -1);
        issue(0, 1'b0, 2'd0, 8'hFF);
        wait_done(0, 300);

        // Back-to-back with Start held high; inputs re-latched per frame.
        expect_frame(1, 16'h035A, 8'h00, -1);
        expect_frame(1, 16'h0181, 8'h00, 2);
        @(posedge CLK); #1;
        rw[1] = 1'b0; ch[1] = 2'd3; duty[1] = 8'h5A; start[1] = 1'b1;
        wait_cs_low(1, 20);
        ch[1] = 2'd1; duty[1] = 8'h81;
        wait_done(1, 100);
        wait_cs_low(1, 20);
        start[1] = 1'b0;
        wait_done(1, 100);
        repeat (60) @(posedge CLK);

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
